// File: rtl/aib_hrdrst_pkg.sv
// rtl/aib_hrdrst_pkg.sv - shared state encoding and defaults for AIB hard-reset sequencing
package aib_hrdrst_pkg;

  // Default number of aux cycles the sequencer reset is held low per attempt
  localparam int AIB_HRDRST_RST_HOLD_DEF = 8;

  typedef enum logic [2:0] {
    HRDRST_IDLE    = 3'd0,
    HRDRST_SEQ_RST = 3'd1,
    HRDRST_M2S     = 3'd2,
    HRDRST_S2M     = 3'd3,
    HRDRST_READY   = 3'd4,
    HRDRST_FAIL    = 3'd5
  } aib_hrdrst_state_e;

  // Plain-vector aliases for FSM code that keeps state as logic [2:0]
  localparam logic [2:0] ST_IDLE    = HRDRST_IDLE;
  localparam logic [2:0] ST_SEQ_RST = HRDRST_SEQ_RST;
  localparam logic [2:0] ST_M2S     = HRDRST_M2S;
  localparam logic [2:0] ST_S2M     = HRDRST_S2M;
  localparam logic [2:0] ST_READY   = HRDRST_READY;
  localparam logic [2:0] ST_FAIL    = HRDRST_FAIL;

  // True in the two phases that wait on a sequencer done and are timed
  function automatic logic phase_active(input logic [2:0] st);
    return (st == ST_M2S) || (st == ST_S2M);
  endfunction

endpackage

// File: rtl/aib_hrdrst_tmr.sv
// rtl/aib_hrdrst_tmr.sv - saturating phase timer with compare-to-limit
module aib_hrdrst_tmr #(
  parameter int W = 16
) (
  input  logic         i_aux_clk,
  input  logic         i_rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Count cycles spent in a phase; clear wins, stop at all-ones
  always_ff @(posedge i_aux_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

  // A zero limit disables expiry; otherwise the phase lasts exactly limit cycles
  assign expired = (limit != '0) && (cnt == (limit - W'(1)));

endmodule

// File: rtl/aib_hrdrst_ctrl.sv
// rtl/aib_hrdrst_ctrl.sv - AIB hard-reset bring-up controller with timeout and retry
module aib_hrdrst_ctrl
  import aib_hrdrst_pkg::*;
#(
  parameter int TIMEOUT_W = 16,
  parameter int MAX_RETRY = 3,
  parameter int RST_HOLD  = AIB_HRDRST_RST_HOLD_DEF
) (
  input  logic                           i_aux_clk,
  input  logic                           i_rst_n,
  input  logic                           i_conf_done,
  input  logic [TIMEOUT_W-1:0]           i_timeout,
  output logic                           o_seq_rst_n,
  output logic                           o_m2s_start,
  input  logic                           i_m2s_done,
  output logic                           o_s2m_start,
  input  logic                           i_s2m_done,
  output logic                           o_link_up,
  output logic                           o_fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] o_retry_cnt,
  output logic [2:0]                     o_state
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int HOLD_W  = $clog2(RST_HOLD + 1);

  logic [2:0]         state, state_d;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               m2s_done_q, s2m_done_q;
  logic               take_retry;
  logic               retry_ok;
  logic               hold_done;
  logic               ready_lost;
  logic               tmr_clear, tmr_en, tmr_expired;

  assign retry_ok   = retry_cnt < RETRY_W'(MAX_RETRY);
  assign hold_done  = hold_cnt == HOLD_W'(RST_HOLD - 1);
  assign ready_lost = (m2s_done_q && !i_m2s_done) || (s2m_done_q && !i_s2m_done);

  // Timer restarts on entry to each timed phase and only runs inside one
  assign tmr_clear = ((state_d == ST_M2S) && (state != ST_M2S)) ||
                     ((state_d == ST_S2M) && (state != ST_S2M));
  assign tmr_en    = phase_active(state);

  aib_hrdrst_tmr #(.W(TIMEOUT_W)) u_tmr (
    .i_aux_clk (i_aux_clk),
    .i_rst_n   (i_rst_n),
    .clear     (tmr_clear),
    .enable    (tmr_en),
    .limit     (i_timeout),
    .expired   (tmr_expired)
  );

  // Next-state: done beats timeout, retry or give up, conf_done low overrides all
  always_comb begin
    state_d    = state;
    take_retry = 1'b0;
    case (state)
      ST_IDLE:    if (i_conf_done) state_d = ST_SEQ_RST;
      ST_SEQ_RST: if (hold_done) state_d = ST_M2S;
      ST_M2S: begin
        if (i_m2s_done)       state_d = ST_S2M;
        else if (tmr_expired) take_retry = 1'b1;
      end
      ST_S2M: begin
        if (i_s2m_done)       state_d = ST_READY;
        else if (tmr_expired) take_retry = 1'b1;
      end
      ST_READY:   if (ready_lost) take_retry = 1'b1;
      ST_FAIL:    state_d = ST_FAIL;
      default:    state_d = ST_IDLE;
    endcase
    if (take_retry) state_d = retry_ok ? ST_SEQ_RST : ST_FAIL;
    if (!i_conf_done) begin
      state_d    = ST_IDLE;
      take_retry = 1'b0;
    end
  end

  // State, hold counter, retry count and done history
  always_ff @(posedge i_aux_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      retry_cnt  <= '0;
      m2s_done_q <= 1'b0;
      s2m_done_q <= 1'b0;
    end else begin
      state      <= state_d;
      m2s_done_q <= i_m2s_done;
      s2m_done_q <= i_s2m_done;
      if ((state == ST_SEQ_RST) && (state_d == ST_SEQ_RST)) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                                                   hold_cnt <= '0;
      if (state_d == ST_IDLE)        retry_cnt <= '0;
      else if (take_retry && retry_ok) retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end

  // Outputs registered from the next state so they change together with it
  always_ff @(posedge i_aux_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seq_rst_n <= 1'b0;
      o_m2s_start <= 1'b0;
      o_s2m_start <= 1'b0;
      o_link_up   <= 1'b0;
      o_fail      <= 1'b0;
    end else begin
      o_seq_rst_n <= (state_d == ST_M2S) || (state_d == ST_S2M) || (state_d == ST_READY);
      o_m2s_start <= (state_d == ST_M2S) || (state_d == ST_S2M) || (state_d == ST_READY);
      o_s2m_start <= (state_d == ST_S2M) || (state_d == ST_READY);
      o_link_up   <= (state_d == ST_READY);
      o_fail      <= (state_d == ST_FAIL);
    end
  end

  assign o_retry_cnt = retry_cnt;
  assign o_state     = state;

endmodule

// File: tb/tb_aib_hrdrst_ctrl.sv
// tb/tb_aib_hrdrst_ctrl.sv - bench for aib_hrdrst_ctrl
module tb_aib_hrdrst_ctrl;
  import aib_hrdrst_pkg::*;

  localparam int HOLD  = 8;
  localparam int MAX_R = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        conf_done;
  logic [15:0] timeout;
  logic        m2s_done, s2m_done;
  logic        seq_rst_n, m2s_start, s2m_start, link_up, fail;
  logic [1:0]  retry_cnt;
  logic [2:0]  state;

  int n_vec = 0;
  int n_bad = 0;

  aib_hrdrst_ctrl #(.TIMEOUT_W(16), .MAX_RETRY(MAX_R), .RST_HOLD(HOLD)) dut (
    .i_aux_clk   (clk),
    .i_rst_n     (rst_n),
    .i_conf_done (conf_done),
    .i_timeout   (timeout),
    .o_seq_rst_n (seq_rst_n),
    .o_m2s_start (m2s_start),
    .i_m2s_done  (m2s_done),
    .o_s2m_start (s2m_start),
    .i_s2m_done  (s2m_done),
    .o_link_up   (link_up),
    .o_fail      (fail),
    .o_retry_cnt (retry_cnt),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         ncyc;
    bit         conf, m2s, s2m;
    int         tmo;
    logic [2:0] st;
    bit         rstn, ms, ss, lk, fl;
    int         retry;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, int ncyc, bit conf, bit m2s, bit s2m, int tmo,
                              logic [2:0] st, bit rstn, bit ms, bit ss, bit lk, bit fl, int retry);
    vec_t v;
    v.name = name; v.ncyc = ncyc; v.conf = conf; v.m2s = m2s; v.s2m = s2m; v.tmo = tmo;
    v.st = st; v.rstn = rstn; v.ms = ms; v.ss = ss; v.lk = lk; v.fl = fl; v.retry = retry;
    vecs.push_back(v);
  endfunction

  task automatic step(int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(string name, bit chk_st, logic [2:0] est, bit er, bit em, bit es,
                     bit el, bit ef, int eretry);
    logic [7:0] act, exp;
    act = {chk_st ? state : 3'd0, seq_rst_n, m2s_start, s2m_start, link_up, fail};
    exp = {chk_st ? est : 3'd0, er, em, es, el, ef};
    n_vec++;
    if ((act !== exp) || (retry_cnt !== 2'(eretry))) begin
      n_bad++;
      $display("FAIL %s: got st=%0d rstn=%0b m2s=%0b s2m=%0b link=%0b fail=%0b retry=%0d, expected st=%0d rstn=%0b m2s=%0b s2m=%0b link=%0b fail=%0b retry=%0d",
               name, act[7:5], act[4], act[3], act[2], act[1], act[0], retry_cnt,
               exp[7:5], er, em, es, el, ef, eretry);
    end
  endtask

  // Reference model: phase plus cycles spent in it, from the bring-up rules
  typedef enum int {P_IDLE, P_RST, P_M2S, P_S2M, P_UP, P_FAIL} ph_t;
  ph_t m_ph;
  int  m_el, m_retry;
  bit  m_pm, m_ps;

  task automatic model_reset();
    m_ph = P_IDLE; m_el = 0; m_retry = 0; m_pm = 0; m_ps = 0;
  endtask

  task automatic model_step(bit conf, bit m2s, bit s2m, int tmo);
    bit retry = 0;
    if (!conf) begin
      m_ph = P_IDLE; m_retry = 0;
    end else begin
      case (m_ph)
        P_IDLE: begin m_ph = P_RST; m_el = 1; end
        P_RST:  if (m_el == HOLD) begin m_ph = P_M2S; m_el = 1; end else m_el++;
        P_M2S:  if (m2s) begin m_ph = P_S2M; m_el = 1; end
                else if (tmo != 0 && m_el == tmo) retry = 1; else m_el++;
        P_S2M:  if (s2m) m_ph = P_UP;
                else if (tmo != 0 && m_el == tmo) retry = 1; else m_el++;
        P_UP:   if ((m_pm && !m2s) || (m_ps && !s2m)) retry = 1;
        default: ;
      endcase
      if (retry) begin
        if (m_retry < MAX_R) begin m_retry++; m_ph = P_RST; m_el = 1; end
        else m_ph = P_FAIL;
      end
    end
    m_pm = m2s; m_ps = s2m;
  endtask

  initial begin
    rst_n = 0; conf_done = 0; timeout = 16'd100; m2s_done = 0; s2m_done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Nominal bring-up, cycle numbers counted from the IDLE cycle conf_done rises in
    add("reset",          0, 0,0,0,100, ST_IDLE,   0,0,0,0,0, 0);
    add("nom_seqrst",     1, 1,0,0,100, ST_SEQ_RST,0,0,0,0,0, 0);
    add("nom_hold",       7, 1,0,0,100, ST_SEQ_RST,0,0,0,0,0, 0);
    add("nom_rst_rise",   1, 1,0,0,100, ST_M2S,    1,1,0,0,0, 0);
    add("nom_m2s_wait",  11, 1,0,0,100, ST_M2S,    1,1,0,0,0, 0);
    add("nom_s2m_start",  1, 1,1,0,100, ST_S2M,    1,1,1,0,0, 0);
    add("nom_s2m_wait",  19, 1,1,0,100, ST_S2M,    1,1,1,0,0, 0);
    add("nom_link_up",    1, 1,1,1,100, ST_READY,  1,1,1,1,0, 0);
    add("nom_ready_hold", 5, 1,1,1,100, ST_READY,  1,1,1,1,0, 0);
    add("ready_m2s_fall", 1, 1,0,1,100, ST_SEQ_RST,0,0,0,0,0, 1);
    add("abort_idle",     1, 0,0,1,100, ST_IDLE,   0,0,0,0,0, 0);
    // Single timeout then success
    add("tmo_first_m2s",  9, 1,0,0,16,  ST_M2S,    1,1,0,0,0, 0);
    add("tmo_last_m2s",  15, 1,0,0,16,  ST_M2S,    1,1,0,0,0, 0);
    add("tmo_retry",      1, 1,0,0,16,  ST_SEQ_RST,0,0,0,0,0, 1);
    add("tmo_hold",       7, 1,0,0,16,  ST_SEQ_RST,0,0,0,0,0, 1);
    add("tmo_m2s2",       1, 1,0,0,16,  ST_M2S,    1,1,0,0,0, 1);
    add("tmo_s2m",        1, 1,1,0,16,  ST_S2M,    1,1,1,0,0, 1);
    add("tmo_link",       1, 1,1,1,16,  ST_READY,  1,1,1,1,0, 1);
    add("tmo_abort",      1, 0,1,1,16,  ST_IDLE,   0,0,0,0,0, 0);
    // Exhaustion: four attempts of 8 + 16 cycles each
    add("exh_m2s4",      96, 1,0,0,16,  ST_M2S,    1,1,0,0,0, 3);
    add("exh_fail",       1, 1,0,0,16,  ST_FAIL,   0,0,0,0,1, 3);
    add("exh_stuck",     10, 1,1,1,16,  ST_FAIL,   0,0,0,0,1, 3);
    add("exh_clear",      1, 0,0,0,16,  ST_IDLE,   0,0,0,0,0, 0);
    // Done on the exact timeout cycle, in both phases
    add("col_m2s_wait",  24, 1,0,0,16,  ST_M2S,    1,1,0,0,0, 0);
    add("col_m2s_hit",    1, 1,1,0,16,  ST_S2M,    1,1,1,0,0, 0);
    add("col_s2m_wait",  15, 1,1,0,16,  ST_S2M,    1,1,1,0,0, 0);
    add("col_s2m_hit",    1, 1,1,1,16,  ST_READY,  1,1,1,1,0, 0);
    add("col_abort",      1, 0,1,1,16,  ST_IDLE,   0,0,0,0,0, 0);
    // Timeout disabled: long wait past counter saturation
    add("dis_m2s",    70000, 1,0,0,0,   ST_M2S,    1,1,0,0,0, 0);
    add("dis_abort",      1, 0,0,0,0,   ST_IDLE,   0,0,0,0,0, 0);

    foreach (vecs[i]) begin
      conf_done = vecs[i].conf; m2s_done = vecs[i].m2s; s2m_done = vecs[i].s2m;
      timeout = 16'(vecs[i].tmo);
      step(vecs[i].ncyc);
      chk(vecs[i].name, 1, vecs[i].st, vecs[i].rstn, vecs[i].ms, vecs[i].ss,
          vecs[i].lk, vecs[i].fl, vecs[i].retry);
    end

    // Asynchronous reset in the middle of S2M
    conf_done = 1; m2s_done = 0; s2m_done = 0; timeout = 16'd0;
    step(9);
    m2s_done = 1;
    step(1);
    chk("ar_in_s2m", 1, ST_S2M, 1,1,1,0,0, 0);
    #2 rst_n = 0;
    #1 chk("ar_immediate", 1, ST_IDLE, 0,0,0,0,0, 0);
    @(negedge clk);
    rst_n = 1;
    chk("ar_held", 1, ST_IDLE, 0,0,0,0,0, 0);
    step(1);
    chk("ar_restart", 1, ST_SEQ_RST, 0,0,0,0,0, 0);

    // Randomized run against the reference model
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 6000; c++) begin
      if (c % 300 == 0) timeout = ($urandom % 4 == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      conf_done = ($urandom % 97) != 0;
      if ($urandom % 5 == 0) m2s_done = ~m2s_done;
      if ($urandom % 5 == 0) s2m_done = ~s2m_done;
      @(posedge clk);
      model_step(conf_done, m2s_done, s2m_done, int'(timeout));
      @(negedge clk);
      chk($sformatf("rand_%0d", c), 0, 3'd0,
          m_ph inside {P_M2S, P_S2M, P_UP}, m_ph inside {P_M2S, P_S2M, P_UP},
          m_ph inside {P_S2M, P_UP}, m_ph == P_UP, m_ph == P_FAIL, m_retry);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
